// File: rtl/switch_matrix_cfg.sv
// switch_matrix_cfg: runtime-configurable switch box with shadow/active routing banks
module switch_matrix_cfg #(
    parameter int NTB = 5,
    parameter int NLR = 4,
    parameter int IDX_W = 3,
    parameter int ADDR_W = 5,
    parameter int REG_OUT = 0,
    localparam int NPIN = 2 * NTB + 2 * NLR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NPIN-1:0]   i_pin_in,
    output logic [NPIN-1:0]   o_pin_out,
    output logic [NPIN-1:0]   o_pin_oe,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [IDX_W+2:0]  i_cfg_data,
    input  logic              i_cfg_commit,
    output logic              o_cfg_busy,
    output logic              o_cfg_err,
    input  logic              i_cfg_err_clr
);
    localparam int DW = IDX_W + 3;
    localparam logic [1:0] S_IDLE = 2'd0, S_COMMIT = 2'd1, S_CLEARERR = 2'd2;

    logic [1:0]       r_state;
    logic [DW-1:0]    r_shadow [NPIN];
    logic [DW-1:0]    r_active [NPIN];
    logic             r_err;
    logic [2:0]       w_side;
    logic [IDX_W-1:0] w_idx;
    logic             w_acc;
    logic             w_legal;
    logic [NPIN-1:0]  w_out;
    logic [NPIN-1:0]  w_oe;

    function automatic int flat(input logic [2:0] side, input logic [IDX_W-1:0] idx);
        return int'(idx) + (side == 3'd2 ? NTB : side == 3'd3 ? NTB + NLR : side == 3'd4 ? 2 * NTB + NLR : 0);
    endfunction

    assign o_cfg_ready = r_state == S_IDLE;
    assign o_cfg_busy = r_state == S_COMMIT || r_state == S_CLEARERR;
    assign o_cfg_err = r_err;

    always_comb begin
        w_side = i_cfg_data[2:0];
        w_idx = i_cfg_data[DW-1:3];
        w_acc = i_cfg_valid && o_cfg_ready;
        w_legal = int'(i_cfg_addr) < NPIN && w_side <= 3'd4 &&
                  (w_side == 3'd0 || (int'(w_idx) < ((w_side == 3'd1 || w_side == 3'd3) ? NTB : NLR) &&
                                      flat(w_side, w_idx) != int'(i_cfg_addr)));
    end

    // Shadow writes and the commit copy never coincide: writes are refused while in COMMIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_err <= 1'b0;
            for (int p = 0; p < NPIN; p++) begin
                r_shadow[p] <= '0;
                r_active[p] <= '0;
            end
        end else begin
            r_state <= (r_state == S_IDLE && i_cfg_commit) ? S_COMMIT : S_IDLE;
            r_err <= i_cfg_err_clr ? 1'b0 : (w_acc && !w_legal) ? 1'b1 : r_err;
            for (int p = 0; p < NPIN; p++) begin
                if (w_acc && w_legal && int'(i_cfg_addr) == p) r_shadow[p] <= i_cfg_data;
                if (r_state == S_COMMIT) r_active[p] <= r_shadow[p];
            end
        end
    end

    always_comb begin
        w_oe = '0;
        w_out = '0;
        for (int p = 0; p < NPIN; p++) begin
            w_oe[p] = r_active[p][2:0] != 3'd0;
            for (int q = 0; q < NPIN; q++)
                if (w_oe[p] && flat(r_active[p][2:0], r_active[p][DW-1:3]) == q) w_out[p] = i_pin_in[q];
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [NPIN-1:0] r_out;
        logic [NPIN-1:0] r_oe;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_out <= '0;
                r_oe <= '0;
            end else begin
                r_out <= w_out;
                r_oe <= w_oe;
            end
        end
        assign o_pin_out = r_out;
        assign o_pin_oe = r_oe;
    end else begin : g_comb
        assign o_pin_out = w_out;
        assign o_pin_oe = w_oe;
    end
endmodule

// File: doc/switch_matrix_cfg.md
# switch_matrix_cfg

Runtime-configurable, parametrised switch box for the FPGA routing fabric. Each pin on the four sides (top, right, bottom, left) can be driven from any input pin on any side, or left undriven. Routing is held in a shadow/active register pair: the configuration port writes the shadow bank, and a commit copies it into the active bank atomically. The block replaces statically initialised switch boxes, so a bitstream loader can reprogram routing without glitching live nets.

## Interface
Parameters:
- NTB, 5: pins on each of the top and bottom sides.
- NLR, 4: pins on each of the left and right sides.
- IDX_W, 3: index field width; must satisfy 2^IDX_W >= max(NTB, NLR).
- NPIN, 2*NTB+2*NLR: total pin count (derived, not overridable).
- ADDR_W, 5: config address width; must satisfy 2^ADDR_W >= NPIN.
- REG_OUT, 0: 0 gives combinational routing; 1 registers pin outputs and enables (1-cycle latency).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- pin_in, in, NPIN: fabric inputs, flat-numbered top[0..NTB-1], right[0..NLR-1], bottom[0..NTB-1], left[0..NLR-1].
- pin_out, out, NPIN: routed output value per pin.
- pin_oe, out, NPIN: output enable per pin; 0 means undriven (the pad wrapper tristates it).
- cfg_valid, in, 1: a config write is offered.
- cfg_ready, out, 1: the block can accept a write.
- cfg_addr, in, ADDR_W: flat index of the destination pin.
- cfg_data, in, IDX_W+3: {src_idx[IDX_W-1:0], src_side[2:0]}. Side codes: 0 undriven, 1 top, 2 right, 3 bottom, 4 left.
- cfg_commit, in, 1: single-cycle pulse requesting shadow-to-active copy.
- cfg_busy, out, 1: a commit is pending or in progress.
- cfg_err, out, 1: sticky illegal-write flag.
- cfg_err_clr, in, 1: clears cfg_err.

## Operation
- Routing from the active word of pin p:
  - pin_oe[p] = (side != 0).
  - pin_out[p] = pin_in[flat(side, idx)] when pin_oe[p] = 1, else 0.
  - flat(): top = idx, right = NTB+idx, bottom = NTB+NLR+idx, left = 2*NTB+NLR+idx.
- Only pin_in is read, never pin_out, so no combinational loop is possible.
- The state machine has three states: IDLE, COMMIT, CLEARERR (CLEARERR is not used; the error is cleared directly).
  - IDLE: cfg_ready = 1 and cfg_busy = 0.
  - A write is accepted when cfg_valid && cfg_ready.
  - A write is legal when all of the following hold: cfg_addr < NPIN; src_side <= 4; src_idx < side length (NTB for top/bottom, NLR for left/right), unless side is 0; and flat(side, idx) != cfg_addr (no self-routing).
  - A legal write updates shadow[cfg_addr] at the next edge.
  - An illegal write is consumed (the handshake completes), the shadow is unchanged, and cfg_err is set.
  - A cfg_commit in IDLE moves the FSM to COMMIT at the next edge.
  - COMMIT lasts exactly 1 cycle: active <= shadow (all pins in the same edge), cfg_ready = 0, cfg_busy = 1, then the FSM returns to IDLE.
- A commit in the same cycle as an accepted write: the write lands in the shadow first, and the following COMMIT copies it.
- A commit while in COMMIT is ignored (it does not queue).
- cfg_err_clr takes priority over a same-cycle error set.
- Reset: shadow and active are all zeros (every pin undriven), FSM goes to IDLE, cfg_err = 0.
  - Reset mid-commit abandons the copy; active becomes all zeros.

## Timing
- Reset values: pin_out = 0, pin_oe = 0, cfg_ready = 1 (from the first cycle after reset), cfg_busy = 0, cfg_err = 0.
- Write: the shadow updates at the edge where the handshake completes. Shadow writes have no effect on the outputs.
- Commit: the pulse at edge N puts the FSM in COMMIT during cycle N+1. The active bank updates at edge N+2, when the FSM returns to IDLE.
  - REG_OUT=0: the new routing is visible after edge N+2.
  - REG_OUT=1: the new routing is visible after edge N+3.
- REG_OUT=1: pin_out and pin_oe are flops and follow pin_in changes with 1-cycle latency.
- REG_OUT=0: pin_out and pin_oe are combinational from pin_in and the active bank.
- Throughput: one write per cycle while in IDLE. Each commit costs one cycle with cfg_ready low.

## Test plan
- Reset, then drive pin_in = all ones -> pin_oe = 0 and pin_out = 0 on every pin.
- Write addr 0 (top0) with data {idx=2, side=4}; hold pin_in[2*NTB+NLR+2] = 1 (left2); commit -> with REG_OUT=0, pin_oe[0] = 1 and pin_out[0] = 1 two cycles after the commit pulse; pin_out[0] then tracks toggles of left2.
- Write addr 5 (right0) {idx=0, side=1}; do not commit -> pin_oe[5] stays 0. Commit -> after commit, pin_out[5] tracks pin_in[0]. Repeat the check with cfg_ready observed low in the COMMIT cycle.
- Illegal writes: addr 18; side 5; {idx=4, side=2} (NLR = 4); addr 0 with {idx=0, side=1} -> each sets cfg_err = 1, and a following commit leaves routing unchanged. cfg_err_clr -> cfg_err = 0.
- Write and commit in the same cycle -> the write is included in the resulting active bank. A second commit during COMMIT -> no extra busy cycle.
- Assert rst during the COMMIT cycle -> all pin_oe = 0 next cycle, and a subsequent commit without writes keeps everything undriven. REG_OUT=1 build: routing latency is one cycle greater than the REG_OUT=0 build.
